mant_mul_seq: RTL and testbench

Sequential radix-2 shift-and-add unsigned mantissa multiplier for the floating-point multiply datapath. It accepts two WIDTH-bit significands (hidden bit included) and produces the full 2*WIDTH-bit product after WIDTH iteration cycles. It sits directly upstream of the product normalize/round stage, and its per-cycle accumulate uses the team's ripple-carry adder family (WIDTH-bit add with carry-in/carry-out).

---
 rtl/mant_mul_seq.sv | 136 +++++++++++++
 tb/tb_mant_mul_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mant_mul_seq.sv
// ============================================================================
// Module      : mant_mul_seq
// Description : Radix-2 shift-and-add unsigned significand multiplier,
//               one ripple-carry add per cycle, full 2*WIDTH-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mant_mul_seq #(
    parameter int WIDTH = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_mant_a,
    input  logic [WIDTH-1:0]     i_mant_b,
    input  logic                 i_ack,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int              CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q,  state_d;
    logic [WIDTH-1:0]     mcand_q,  mcand_d;
    logic [2*WIDTH:0]     acc_q,    acc_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [2*WIDTH-1:0]   w_shift;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start)          state_d = S_RUN;
            S_RUN:   if (cnt_q == C_LAST)  state_d = S_DONE;
            S_DONE:  if (i_ack)            state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (all outputs come straight from registers)
    // ------------------------------------------------------------------
    always_comb begin
        o_busy    = (state_q == S_RUN);
        o_valid   = (state_q == S_DONE);
        o_product = result_q;
    end

    // ------------------------------------------------------------------
    // WIDTH-bit ripple-carry accumulate of the partial sum
    // ------------------------------------------------------------------
    always_comb begin
        logic c;
        w_addend = acc_q[0] ? mcand_q : '0;
        w_sum    = '0;
        c        = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i] = acc_q[WIDTH+i] ^ w_addend[i] ^ c;
            c        = (acc_q[WIDTH+i] & w_addend[i]) |
                       (c & (acc_q[WIDTH+i] ^ w_addend[i]));
        end
        // Top partial-sum bit is zero after every shift; folding it in keeps the add exact.
        w_cout  = c ^ acc_q[2*WIDTH];
        w_shift = {w_cout, w_sum, acc_q[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mcand_d = i_mant_a;
                    acc_d   = {{(WIDTH+1){1'b0}}, i_mant_b};
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                acc_d = {1'b0, w_shift};
                cnt_d = cnt_q + C_ONE;
                if (cnt_q == C_LAST) begin
                    result_d = w_shift;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mant_mul_seq.sv
// ============================================================================
// Module      : tb_mant_mul_seq
// Description : Scoreboard bench for mant_mul_seq: directed products, protocol
//               stress, asynchronous abort and a short random sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mant_mul_seq;

    localparam int WIDTH = 24;

    logic                 i_clk;
    logic                 i_rst;
    logic                 i_start;
    logic [WIDTH-1:0]     i_mant_a;
    logic [WIDTH-1:0]     i_mant_b;
    logic                 i_ack;
    logic                 o_busy;
    logic                 o_valid;
    logic [2*WIDTH-1:0]   o_product;

    int n_vec = 0;
    int n_err = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    mant_mul_seq #(.WIDTH(WIDTH)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_mant_a  (i_mant_a),
        .i_mant_b  (i_mant_b),
        .i_ack     (i_ack),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_product (o_product)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string nm, input logic [2*WIDTH-1:0] act,
                       input logic [2*WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every rising edge of o_valid.
    initial begin
        bit vp;
        vp = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                vp = 1'b0;
            end else begin
                if (o_busy && o_valid) begin
                    n_err++;
                    $display("FAIL busy_valid_overlap: busy=%b valid=%b, expected not both", o_busy, o_valid);
                end
                if (o_valid && !vp) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_valid: got product %h, expected no result", o_product);
                    end else begin
                        chk("product", o_product, exp_q.pop_front());
                    end
                end
                vp = o_valid;
            end
        end
    end

    // Issue one multiply starting at the next edge, then acknowledge after ack_dly DONE cycles.
    task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2*WIDTH-1:0] exp, input int ack_dly, input bit hold);
        int  lat;
        int  busy_n;
        bit  got;
        i_mant_a = a;
        i_mant_b = b;
        i_start  = 1'b1;
        exp_q.push_back(exp);
        @(posedge i_clk); #1;
        if (!hold) i_start = 1'b0;
        lat = 0; busy_n = 0; got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            if (o_busy) busy_n++;
            if (hold) begin
                i_mant_a = WIDTH'($urandom);
                i_mant_b = WIDTH'($urandom);
            end
            @(posedge i_clk); #1;
            if (o_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        i_start = 1'b0;
        chk("latency", 48'(lat), 48'(WIDTH));
        chk("busy_cycles", 48'(busy_n), 48'(WIDTH));
        if (!got) begin
            void'(exp_q.pop_back());
            return;
        end
        for (int d = 0; d < ack_dly; d++) begin
            @(posedge i_clk); #1;
            chk("valid_hold", 48'(o_valid), 48'd1);
            chk("product_hold", o_product, exp);
        end
        i_ack = 1'b1;
        @(posedge i_clk); #1;
        i_ack = 1'b0;
        chk("ack_clears_valid", 48'(o_valid), 48'd0);
        chk("product_kept", o_product, exp);
    endtask

    initial begin
        bit saw_valid;
        logic [WIDTH-1:0] ra, rb;
        i_rst = 1'b1; i_start = 1'b0; i_ack = 1'b0;
        i_mant_a = '0; i_mant_b = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy", 48'(o_busy), 48'd0);
        chk("rst_valid", 48'(o_valid), 48'd0);
        chk("rst_product", o_product, 48'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        do_mul(24'h800000, 24'h800000, 48'h400000000000, 0, 1'b0);
        do_mul(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1, 1'b0);
        do_mul(24'hC00000, 24'hC00000, 48'h900000000000, 0, 1'b0);
        do_mul(24'h000000, 24'hABCDEF, 48'h000000000000, 2, 1'b0);
        // Start held high with operands churning; ack withheld for 10 cycles.
        do_mul(24'h123456, 24'h000010, 48'h000001234560, 10, 1'b1);
        // Start on the edge right after ack.
        do_mul(24'h000ABC, 24'h000100, 48'h0000000ABC00, 0, 1'b0);

        // Asynchronous abort at iteration 12.
        i_mant_a = 24'hFFFFFF; i_mant_b = 24'hFFFFFF; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (12) @(posedge i_clk);
        #2;
        chk("busy_before_abort", 48'(o_busy), 48'd1);
        i_rst = 1'b1;
        #1;
        chk("abort_busy", 48'(o_busy), 48'd0);
        chk("abort_valid", 48'(o_valid), 48'd0);
        chk("abort_product", o_product, 48'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) saw_valid = 1'b1;
        end
        chk("no_valid_after_abort", 48'(saw_valid), 48'd0);
        do_mul(24'h000003, 24'h000005, 48'h00000000000F, 0, 1'b0);

        // Short random sweep against a*b.
        for (int n = 0; n < 200; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            do_mul(ra, rb, 48'(ra) * 48'(rb), int'($urandom_range(0, 5)), 1'b0);
        end

        repeat (3) @(posedge i_clk);
        #1;
        chk("scoreboard_drained", 48'(exp_q.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
